// File: rtl/ysyx_22040237_ctrl_pkg.sv
// ysyx_22040237_ctrl_pkg: shared state encoding and constants for the instruction sequencer
package ysyx_22040237_ctrl_pkg;
    typedef enum logic [3:0] {
        ST_RESET,
        ST_FETCH_REQ,
        ST_FETCH_WAIT,
        ST_DECODE,
        ST_EXEC,
        ST_MEM_REQ,
        ST_MEM_WAIT,
        ST_WB,
        ST_HALT
    } state_t;

    localparam logic [1:0] TRAP_NONE    = 2'd0;
    localparam logic [1:0] TRAP_EBREAK  = 2'd1;
    localparam logic [1:0] TRAP_ILLEGAL = 2'd2;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
endpackage

// File: rtl/ysyx_22040237_pcgen.sv
// ysyx_22040237_pcgen: program counter with sequential / jal next-PC selection
module ysyx_22040237_pcgen
    import ysyx_22040237_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        jump,
    input  logic [31:0] src_j,
    output logic [31:0] pc
);
    logic [31:0] next_pc;

    assign next_pc = jump ? pc + src_j : pc + 32'd4;

    // PC only moves on the retire cycle; both adds wrap modulo 2^32
    always_ff @(posedge clk) begin
        if (!rst_n)
            pc <= RESET_PC;
        else if (en)
            pc <= next_pc;
    end
endmodule

// File: rtl/ysyx_22040237_ctrl.sv
// ysyx_22040237_ctrl: multi-cycle fetch/decode/execute/memory/writeback sequencer
module ysyx_22040237_ctrl
    import ysyx_22040237_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ifu_req_valid,
    input  logic        ifu_req_ready,
    output logic [31:0] ifu_addr,
    input  logic        ifu_rsp_valid,
    input  logic [31:0] ifu_rsp_inst,
    output logic [31:0] pc,
    output logic [31:0] inst,
    input  logic        dec_jump_flag,
    input  logic [31:0] dec_src_j,
    input  logic        dec_ebreak,
    input  logic        dec_illegal,
    input  logic        dec_mem_en,
    input  logic        dec_rd_w_en,
    output logic        lsu_req_valid,
    input  logic        lsu_req_ready,
    input  logic        lsu_rsp_valid,
    output logic        rf_w_en,
    output logic        halted,
    output logic [1:0]  trap_code,
    output logic [63:0] inst_cnt
);
    state_t state, next_state;
    logic   retire;

    assign retire   = state == ST_WB;
    assign ifu_addr = pc;

    ysyx_22040237_pcgen #(.RESET_PC(RESET_PC)) u_pcgen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (retire),
        .jump  (dec_jump_flag),
        .src_j (dec_src_j),
        .pc    (pc)
    );

    // State register; reset parks the FSM in ST_RESET so stale responses are ignored
    always_ff @(posedge clk) begin
        state <= !rst_n ? ST_RESET : next_state;
    end

    // Next-state and per-state request/strobe outputs
    always_comb begin
        next_state    = state;
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        rf_w_en       = 1'b0;
        halted        = 1'b0;
        case (state)
            ST_RESET:      next_state = ST_FETCH_REQ;
            ST_FETCH_REQ: begin
                ifu_req_valid = 1'b1;
                next_state    = ifu_req_ready ? ST_FETCH_WAIT : ST_FETCH_REQ;
            end
            ST_FETCH_WAIT: next_state = ifu_rsp_valid ? ST_DECODE : ST_FETCH_WAIT;
            ST_DECODE:     next_state = (dec_illegal || dec_ebreak) ? ST_HALT : ST_EXEC;
            ST_EXEC:       next_state = dec_mem_en ? ST_MEM_REQ : ST_WB;
            ST_MEM_REQ: begin
                lsu_req_valid = 1'b1;
                next_state    = lsu_req_ready ? ST_MEM_WAIT : ST_MEM_REQ;
            end
            ST_MEM_WAIT:   next_state = lsu_rsp_valid ? ST_WB : ST_MEM_WAIT;
            ST_WB: begin
                rf_w_en    = dec_rd_w_en;
                next_state = ST_FETCH_REQ;
            end
            ST_HALT:       halted = 1'b1;
            default:       next_state = ST_RESET;
        endcase
    end

    // Instruction latch, trap capture and retired-instruction counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inst      <= '0;
            trap_code <= TRAP_NONE;
            inst_cnt  <= '0;
        end else begin
            if (state == ST_FETCH_WAIT && ifu_rsp_valid)
                inst <= ifu_rsp_inst;
            if (state == ST_DECODE)
                trap_code <= dec_illegal ? TRAP_ILLEGAL : dec_ebreak ? TRAP_EBREAK : TRAP_NONE;
            if (retire)
                inst_cnt <= inst_cnt + 64'd1;
        end
    end
endmodule

// File: tb/tb_ysyx_22040237_ctrl.sv
// tb_ysyx_22040237_ctrl: directed self-checking bench for the instruction sequencer
module tb_ysyx_22040237_ctrl;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rsp_inst;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        dec_jump_flag;
    logic [31:0] dec_src_j;
    logic        dec_ebreak;
    logic        dec_illegal;
    logic        dec_mem_en;
    logic        dec_rd_w_en;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_rsp_valid;
    logic        rf_w_en;
    logic        halted;
    logic [1:0]  trap_code;
    logic [63:0] inst_cnt;

    int errors;
    int checks;
    int cyc = 0;

    ysyx_22040237_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_addr      (ifu_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_inst  (ifu_rsp_inst),
        .pc            (pc),
        .inst          (inst),
        .dec_jump_flag (dec_jump_flag),
        .dec_src_j     (dec_src_j),
        .dec_ebreak    (dec_ebreak),
        .dec_illegal   (dec_illegal),
        .dec_mem_en    (dec_mem_en),
        .dec_rd_w_en   (dec_rd_w_en),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_rsp_valid (lsu_rsp_valid),
        .rf_w_en       (rf_w_en),
        .halted        (halted),
        .trap_code     (trap_code),
        .inst_cnt      (inst_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst_n         = 1'b0;
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        ifu_rsp_inst  = '0;
        dec_jump_flag = 1'b0;
        dec_src_j     = '0;
        dec_ebreak    = 1'b0;
        dec_illegal   = 1'b0;
        dec_mem_en    = 1'b0;
        dec_rd_w_en   = 1'b0;
        lsu_req_ready = 1'b0;
        lsu_rsp_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Runs one instruction starting in FETCH_REQ; returns the WB cycle, rf_w_en pulse count
    // and the index of the cycle the sequencer reached next (FETCH_REQ or HALT), starting at 1.
    task automatic exec_inst(input logic [31:0] i, input logic jmp, input logic [31:0] sj,
                             input logic eb, input logic ill, input logic mem, input logic rd,
                             input int rdy_wait, input int lsu_wait, input logic [31:0] addr,
                             output int wb_cyc, output int pulses, output int n);
        int   age;
        logic acc;
        age           = 0;
        wb_cyc        = -1;
        pulses        = 0;
        n             = 1;
        dec_jump_flag = jmp;
        dec_src_j     = sj;
        dec_ebreak    = eb;
        dec_illegal   = ill;
        dec_mem_en    = mem;
        dec_rd_w_en   = rd;
        for (int k = 0; k < rdy_wait; k++) begin
            ifu_req_ready = 1'b0;
            checks++;
            if (ifu_req_valid !== 1'b1 || ifu_addr !== addr) begin
                errors++;
                $display("FAIL fetch_hold: valid=%b addr=%h, expected valid=1 addr=%h", ifu_req_valid, ifu_addr, addr);
            end
            tick();
            n++;
        end
        checks++;
        if (ifu_req_valid !== 1'b1 || ifu_addr !== addr) begin
            errors++;
            $display("FAIL fetch_req: valid=%b addr=%h, expected valid=1 addr=%h", ifu_req_valid, ifu_addr, addr);
        end
        ifu_req_ready = 1'b1;
        tick();
        n++;
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = i;
        tick();
        n++;
        ifu_rsp_valid = 1'b0;
        ifu_rsp_inst  = '0;
        for (int k = 0; k < 40; k++) begin
            if (ifu_req_valid || halted) break;
            lsu_rsp_valid = (age > 0 && age == lsu_wait);
            lsu_req_ready = lsu_req_valid;
            acc           = lsu_req_valid;
            if (rf_w_en) begin
                pulses++;
                wb_cyc = cyc;
            end
            tick();
            n++;
            age = acc ? 1 : (age > 0 ? age + 1 : 0);
        end
        lsu_rsp_valid = 1'b0;
        lsu_req_ready = 1'b0;
        checks++;
        if (!(ifu_req_valid === 1'b1 || halted === 1'b1)) begin
            errors++;
            $display("FAIL inst_timeout: sequencer did not return to fetch or halt for inst %h", i);
        end
    endtask

    task automatic test_reset;
        apply_reset();
        checks++;
        if (pc !== RST_PC || inst !== 32'h0 || inst_cnt !== 64'h0 || trap_code !== 2'd0) begin
            errors++;
            $display("FAIL reset_regs: pc=%h inst=%h cnt=%0d trap=%0d, expected %h 0 0 0", pc, inst, inst_cnt, trap_code, RST_PC);
        end
        checks++;
        if ({halted, ifu_req_valid, lsu_req_valid, rf_w_en} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes: halted/ifu/lsu/rf=%b, expected 0000", {halted, ifu_req_valid, lsu_req_valid, rf_w_en});
        end
        ifu_req_ready = 1'b1;
        tick();
        checks++;
        if (ifu_req_valid !== 1'b1 || ifu_addr !== RST_PC) begin
            errors++;
            $display("FAIL first_fetch: valid=%b addr=%h, expected valid=1 addr=%h", ifu_req_valid, ifu_addr, RST_PC);
        end
        ifu_req_ready = 1'b0;
    endtask

    task automatic test_three_addi;
        int base, wb, p, n;
        base = cyc;
        for (int k = 0; k < 3; k++) begin
            exec_inst(32'h0010_0093, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1, RST_PC + 32'(4 * k), wb, p, n);
            checks++;
            if (p !== 1 || wb - base + 1 !== 5 * (k + 1) || n - 1 !== 5) begin
                errors++;
                $display("FAIL addi_%0d: pulses=%0d wb_cycle=%0d latency=%0d, expected 1 %0d 5", k, p, wb - base + 1, n - 1, 5 * (k + 1));
            end
        end
        checks++;
        if (pc !== 32'h8000_000C || ifu_addr !== 32'h8000_000C || inst_cnt !== 64'd3) begin
            errors++;
            $display("FAIL addi_final: pc=%h addr=%h cnt=%0d, expected 8000000c 8000000c 3", pc, ifu_addr, inst_cnt);
        end
    endtask

    task automatic test_jal;
        int wb, p, n;
        exec_inst(32'h0010_0093, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1, 32'h8000_000C, wb, p, n);
        exec_inst(32'hFF9F_F0EF, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1, 32'h8000_0010, wb, p, n);
        checks++;
        if (p !== 1 || ifu_addr !== 32'h8000_0008 || inst_cnt !== 64'd5) begin
            errors++;
            $display("FAIL jal: pulses=%0d addr=%h cnt=%0d, expected 1 80000008 5", p, ifu_addr, inst_cnt);
        end
    endtask

    task automatic test_stall_load;
        int wb, p, n;
        exec_inst(32'h0000_2103, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 3, 4, 32'h8000_0008, wb, p, n);
        checks++;
        if (p !== 1 || n - 1 !== 13 || ifu_addr !== 32'h8000_000C || inst_cnt !== 64'd6 || inst !== 32'h0000_2103) begin
            errors++;
            $display("FAIL stall_load: pulses=%0d latency=%0d addr=%h cnt=%0d inst=%h, expected 1 13 8000000c 6 00002103", p, n - 1, ifu_addr, inst_cnt, inst);
        end
    endtask

    task automatic test_store;
        int wb, p, n;
        exec_inst(32'h0020_2023, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1, 32'h8000_000C, wb, p, n);
        checks++;
        if (p !== 0 || n - 1 !== 7 || pc !== 32'h8000_0010 || inst_cnt !== 64'd7) begin
            errors++;
            $display("FAIL store: pulses=%0d latency=%0d pc=%h cnt=%0d, expected 0 7 80000010 7", p, n - 1, pc, inst_cnt);
        end
    endtask

    task automatic check_halt(input logic [1:0] exp_trap, input logic [63:0] exp_cnt, input logic [31:0] exp_pc, input int p);
        int bad;
        checks++;
        if (halted !== 1'b1 || trap_code !== exp_trap || inst_cnt !== exp_cnt || pc !== exp_pc || p !== 0) begin
            errors++;
            $display("FAIL halt_state: halted=%b trap=%0d cnt=%0d pc=%h pulses=%0d, expected 1 %0d %0d %h 0", halted, trap_code, inst_cnt, pc, p, exp_trap, exp_cnt, exp_pc);
        end
        bad = 0;
        ifu_req_ready = 1'b1;
        lsu_req_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (ifu_req_valid || lsu_req_valid || rf_w_en || !halted || pc !== exp_pc || inst_cnt !== exp_cnt) bad++;
            tick();
        end
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL halt_absorb: %0d bad cycles over 20, expected 0", bad);
        end
    endtask

    task automatic test_ebreak;
        int wb, p, n;
        exec_inst(32'h0010_0073, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 32'h8000_0010, wb, p, n);
        check_halt(2'd1, 64'd7, 32'h8000_0010, p);
    endtask

    task automatic test_illegal;
        int wb, p, n;
        apply_reset();
        checks++;
        if (trap_code !== 2'd0 || halted !== 1'b0 || inst_cnt !== 64'd0) begin
            errors++;
            $display("FAIL reset_from_halt: trap=%0d halted=%b cnt=%0d, expected 0 0 0", trap_code, halted, inst_cnt);
        end
        tick();
        exec_inst(32'h0000_0000, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1, RST_PC, wb, p, n);
        check_halt(2'd2, 64'd0, RST_PC, p);
    endtask

    task automatic test_reset_mid_mem;
        int wb, p, n, bad;
        apply_reset();
        tick();
        exec_inst(32'h0010_0093, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1, RST_PC, wb, p, n);
        dec_mem_en    = 1'b1;
        dec_rd_w_en   = 1'b1;
        ifu_req_ready = 1'b1;
        tick();
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = 32'h0000_2103;
        tick();
        ifu_rsp_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (lsu_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL mem_req: lsu_req_valid=%b, expected 1", lsu_req_valid);
        end
        lsu_req_ready = 1'b1;
        tick();
        lsu_req_ready = 1'b0;
        checks++;
        if (lsu_req_valid !== 1'b0 || rf_w_en !== 1'b0 || inst_cnt !== 64'd1) begin
            errors++;
            $display("FAIL mem_wait: lsu=%b rf=%b cnt=%0d, expected 0 0 1", lsu_req_valid, rf_w_en, inst_cnt);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (pc !== RST_PC || inst !== 32'h0 || inst_cnt !== 64'd0 || trap_code !== 2'd0 ||
            {halted, ifu_req_valid, lsu_req_valid, rf_w_en} !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_regs: pc=%h inst=%h cnt=%0d trap=%0d strobes=%b, expected %h 0 0 0 0000", pc, inst, inst_cnt, trap_code, {halted, ifu_req_valid, lsu_req_valid, rf_w_en}, RST_PC);
        end
        rst_n         = 1'b1;
        lsu_rsp_valid = 1'b1;
        tick();
        checks++;
        if (ifu_req_valid !== 1'b1 || ifu_addr !== RST_PC || rf_w_en !== 1'b0) begin
            errors++;
            $display("FAIL midreset_refetch: valid=%b addr=%h rf=%b, expected 1 %h 0", ifu_req_valid, ifu_addr, rf_w_en, RST_PC);
        end
        tick();
        lsu_rsp_valid = 1'b0;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            if (rf_w_en || !ifu_req_valid || lsu_req_valid || pc !== RST_PC) bad++;
            tick();
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL stale_rsp: %0d bad cycles after stale lsu_rsp_valid, expected 0", bad);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_three_addi();
        test_jal();
        test_stall_load();
        test_store();
        test_ebreak();
        test_illegal();
        test_reset_mid_mem();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/ysyx_22040237_ctrl.md
# ysyx_22040237_ctrl

Multi-cycle instruction sequencer for the ysyx_22040237 core. It owns the PC. It fetches over a valid/ready port, then presents the latched instruction to the decoder. It steps execute, memory access and writeback, and gates the register-file write so it fires exactly once per instruction. It sits above IFU/IDU/EXU/LSU and replaces the single-cycle implicit sequencing.

## Interface
- RESET_PC, 32'h8000_0000, PC value loaded at reset.
- clk  in  1  core clock; all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset.
- ifu_req_valid  out  1  fetch request valid.
- ifu_req_ready  in  1  fetch request accepted when valid & ready.
- ifu_addr  out  32  fetch address, equals pc.
- ifu_rsp_valid  in  1  fetched instruction valid; single-cycle pulse.
- ifu_rsp_inst  in  32  fetched instruction.
- pc  out  32  current PC, to IDU/EXU.
- inst  out  32  latched instruction, to IDU; held from DECODE through WB.
- dec_jump_flag  in  1  decoded jal.
- dec_src_j  in  32  sign-extended jal offset.
- dec_ebreak  in  1  decoded ebreak.
- dec_illegal  in  1  no legal decode (inst_opcode==0 and not ebreak).
- dec_mem_en  in  1  instruction is load/store.
- dec_rd_w_en  in  1  decoder's rd write enable.
- lsu_req_valid, lsu_req_ready  out/in  1  memory request handshake.
- lsu_rsp_valid  in  1  memory op complete; single-cycle pulse.
- rf_w_en  out  1  gated RF write enable.
- halted  out  1  core stopped.
- trap_code  out  2  0 none, 1 ebreak, 2 illegal.
- inst_cnt  out  64  retired-instruction counter.

## Operation
- States: RESET, FETCH_REQ, FETCH_WAIT, DECODE, EXEC, MEM_REQ, MEM_WAIT, WB, HALT.
- RESET: entered while rst_n=0. It exits unconditionally to FETCH_REQ.
- FETCH_REQ: ifu_req_valid=1. On ifu_req_ready it goes to FETCH_WAIT. Otherwise it holds, and ifu_addr stays stable.
- FETCH_WAIT: on ifu_rsp_valid it latches inst and goes to DECODE. ifu_rsp_valid seen in any other state is ignored.
- DECODE, in priority order:
  - dec_illegal: HALT, trap_code=2.
  - dec_ebreak: HALT, trap_code=1.
  - otherwise: EXEC.
- EXEC: goes to MEM_REQ if dec_mem_en, else to WB.
- MEM_REQ: lsu_req_valid=1 until lsu_req_ready, then MEM_WAIT.
- MEM_WAIT: waits for lsu_rsp_valid, then WB.
- WB: one cycle.
  - rf_w_en = dec_rd_w_en.
  - pc <= dec_jump_flag ? pc + dec_src_j : pc + 4. The add is mod 2^32 and wraps silently.
  - inst_cnt += 1.
  - Next state: FETCH_REQ.
- HALT: absorbing until reset.
  - halted=1; no requests issued; pc and inst_cnt frozen.
  - ebreak and illegal instructions do not retire; inst_cnt is not incremented.
- rf_w_en is 0 in every state except WB.

## Timing
- Reset values:
  - pc=RESET_PC, inst=0, inst_cnt=0, trap_code=0.
  - halted, ifu_req_valid, lsu_req_valid and rf_w_en are all 0.
- First ifu_req_valid=1: the first cycle after the cycle in which rst_n is sampled high.
- Minimum latency per instruction, zero-wait memories, no mem op: 5 cycles (FETCH_REQ, FETCH_WAIT, DECODE, EXEC, WB). With a mem op: 7 cycles.
- The response pulse may arrive no earlier than the cycle after the accept.
- Valid stays asserted until its ready. It is never withdrawn except by reset.
- Reset mid-operation (any state, including FETCH_WAIT or MEM_WAIT):
  - All outputs return to reset values on the next edge.
  - The outstanding response is dropped; a late ifu_rsp_valid or lsu_rsp_valid is ignored because the FSM is not in the matching WAIT state.
- inst_cnt wraps 2^64-1 -> 0.

## Structure
- Package ysyx_22040237_ctrl_pkg holds:
  - the state enum;
  - trap-code constants TRAP_NONE, TRAP_EBREAK, TRAP_ILLEGAL;
  - the default RESET_PC.
- Sub-module ysyx_22040237_pcgen holds the PC register, next-PC mux (pc+4 / pc+src_j) and update enable. It is driven by WB.

## Test plan
- Reset release with ifu_req_ready=1 -> ifu_req_valid=1 with ifu_addr=0x8000_0000 on the first cycle after the cycle rst_n is sampled high.
- Three addi instructions, zero-wait IFU -> rf_w_en pulses at cycles 5, 10 and 15; pc=0x8000_000C; inst_cnt=3.
- jal with src_j=0xFFFF_FFF8 at pc=0x8000_0010 -> next ifu_addr=0x8000_0008; rf_w_en=1 in WB.
- ifu_req_ready held low 3 cycles, then a load with lsu_rsp_valid 4 cycles after the accept -> request valid stays high, addr stable, exactly one rf_w_en pulse.
- ebreak fetched -> halted=1, trap_code=1, inst_cnt unchanged, no further ifu_req_valid over 20 cycles. Repeat with illegal 0x0000_0000 -> trap_code=2.
- rst_n dropped in MEM_WAIT, then a stale lsu_rsp_valid after release -> pc=RESET_PC, rf_w_en never asserted, a fresh fetch is issued.
